// File: rtl/cache_write_buffer.sv
// Single-entry write/victim buffer between a cache's pmem port and physical memory.
// Optional build macro: CACHE_WB_FORWARD_EN (reads that hit the buffer are served from it).
module cache_write_buffer #(
    parameter int ADDR_W   = 16,
    parameter int LINE_W   = 128,
    parameter int OFFSET_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [LINE_W-1:0] c_wdata,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] ZERO_OFF = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_ACK
    } state_t;

    state_t              r_state;
    logic                r_buf_valid;
    logic [TAG_W-1:0]    r_buf_tag;
    logic [LINE_W-1:0]   r_buf_data;
    logic                r_c_resp;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_address;
    logic [LINE_W-1:0]   r_pmem_wdata;
    logic [LINE_W-1:0]   r_c_rdata;

    logic [TAG_W-1:0]    w_req_tag;
    logic                w_hit;
    logic                w_fwd;
    logic                w_rd_miss;
    logic                w_wr_accept;
    logic                w_drain;
    logic                w_unused_offset;

    assign w_req_tag       = c_address[ADDR_W-1:OFFSET_W];
    assign w_unused_offset = ^c_address[OFFSET_W-1:0];
    assign w_hit           = r_buf_valid && (r_buf_tag == w_req_tag);

`ifdef CACHE_WB_FORWARD_EN
    assign w_fwd = c_read && w_hit;
`else
    assign w_fwd = 1'b0;
`endif

    // A read that hits without forwarding falls through to w_drain, so the
    // line reaches memory first and the retried read then misses cleanly.
    assign w_rd_miss   = c_read && !w_hit;
    assign w_wr_accept = !c_read && c_write && (!r_buf_valid || w_hit);
    assign w_drain     = r_buf_valid && !w_fwd && !w_rd_miss && !w_wr_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_buf_valid    <= 1'b0;
            r_buf_tag      <= '0;
            r_buf_data     <= '0;
            r_c_resp       <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_c_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fwd) begin
                        r_c_rdata <= r_buf_data;
                        r_c_resp  <= 1'b1;
                        r_state   <= S_ACK;
                    end else if (w_rd_miss) begin
                        r_pmem_read    <= 1'b1;
                        r_pmem_address <= {w_req_tag, ZERO_OFF};
                        r_state        <= S_READ;
                    end else if (w_wr_accept) begin
                        r_buf_valid <= 1'b1;
                        r_buf_tag   <= w_req_tag;
                        r_buf_data  <= c_wdata;
                        r_c_resp    <= 1'b1;
                        r_state     <= S_ACK;
                    end else if (w_drain) begin
                        r_pmem_write   <= 1'b1;
                        r_pmem_address <= {r_buf_tag, ZERO_OFF};
                        r_pmem_wdata   <= r_buf_data;
                        r_state        <= S_DRAIN;
                    end
                end
                S_READ: begin
                    if (pmem_resp) begin
                        r_c_rdata      <= pmem_rdata;
                        r_pmem_read    <= 1'b0;
                        r_pmem_address <= '0;
                        r_c_resp       <= 1'b1;
                        r_state        <= S_ACK;
                    end
                end
                S_DRAIN: begin
                    if (pmem_resp) begin
                        r_buf_valid    <= 1'b0;
                        r_pmem_write   <= 1'b0;
                        r_pmem_address <= '0;
                        r_pmem_wdata   <= '0;
                        r_state        <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_c_resp <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign c_rdata      = r_c_rdata;
    assign c_resp       = r_c_resp;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer: write absorb, read miss, hit, coalesce,
// conflict eviction and reset during drain, with cycle-exact expectations.
module tb_cache_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         c_read;
    logic         c_write;
    logic [15:0]  c_address;
    logic [127:0] c_wdata;
    logic [127:0] c_rdata;
    logic         c_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D2 = 128'hA5A5_0000_FFFF_1234_DEAD_BEEF_CAFE_0001;
    localparam logic [127:0] D3 = 128'h0F0F_F0F0_0123_4567_89AB_CDEF_0000_7777;
    localparam logic [127:0] R1 = 128'h9999_8888_7777_6666_5555_4444_3333_2222;

    cache_write_buffer #(.ADDR_W(16), .LINE_W(128), .OFFSET_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .c_read       (c_read),
        .c_write      (c_write),
        .c_address    (c_address),
        .c_wdata      (c_wdata),
        .c_rdata      (c_rdata),
        .c_resp       (c_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Presents a write into an empty/hit buffer and expects c_resp one cycle later.
    task automatic write_ack(input string tag, input logic [15:0] addr, input logic [127:0] data);
        c_write   = 1'b1;
        c_address = addr;
        c_wdata   = data;
        tick();
        chk(tag, c_resp, 1);
        chk({tag, "_nowr"}, pmem_write, 0);
        c_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; c_read = 1'b0; c_write = 1'b0; c_address = '0;
        c_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_c_resp", c_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_pmem_addr", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);

        // Write into empty buffer, then drain with a 2-cycle memory delay.
        write_ack("t1_ack", 16'h1230, D1);
        tick();
        chk("t1_ack_drop", c_resp, 0);
        chk("t1_idle_nowr", pmem_write, 0);
        tick();
        chk("t1_drain_wr", pmem_write, 1);
        chk("t1_drain_addr", pmem_address, 16'h1230);
        chk("t1_drain_data", pmem_wdata, D1);
        tick(); tick();
        chk("t1_drain_hold", pmem_write, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t1_drain_done", pmem_write, 0);
        chk("t1_no_resp", c_resp, 0);

        // Read miss while buffer holds 0x1230: memory read first, then drain.
        write_ack("t2_ack", 16'h1230, D2);
        c_read = 1'b1; c_address = 16'h4560;
        tick();
        chk("t2_ackcyc_nord", pmem_read, 0);
        tick();
        chk("t2_pmem_read", pmem_read, 1);
        chk("t2_read_addr", pmem_address, 16'h4560);
        chk("t2_no_wr", pmem_write, 0);
        pmem_rdata = R1; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; c_read = 1'b0;
        chk("t2_c_resp", c_resp, 1);
        chk("t2_c_rdata", c_rdata, R1);
        chk("t2_read_drop", pmem_read, 0);
        tick();
        chk("t2_resp_pulse", c_resp, 0);
        tick();
        chk("t2_drain_wr", pmem_write, 1);
        chk("t2_drain_addr", pmem_address, 16'h1230);
        chk("t2_drain_data", pmem_wdata, D2);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t2_drain_done", pmem_write, 0);

        // Read hitting the buffer (0x1238 shares line 0x1230).
        write_ack("t3_ack", 16'h1230, D1);
        c_read = 1'b1; c_address = 16'h1238;
        tick();
        tick();
`ifdef CACHE_WB_FORWARD_EN
        chk("t3_fwd_resp", c_resp, 1);
        chk("t3_fwd_data", c_rdata, D1);
        chk("t3_fwd_nord", pmem_read, 0);
        c_read = 1'b0;
        tick();
        tick();
        chk("t3_drain_wr", pmem_write, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t3_drain_done", pmem_write, 0);
`else
        chk("t3_drain_wr", pmem_write, 1);
        chk("t3_drain_addr", pmem_address, 16'h1230);
        chk("t3_drain_data", pmem_wdata, D1);
        chk("t3_no_read", pmem_read, 0);
        chk("t3_no_resp", c_resp, 0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t3_drain_done", pmem_write, 0);
        tick();
        chk("t3_read", pmem_read, 1);
        chk("t3_read_addr", pmem_address, 16'h1230);
        pmem_rdata = D1; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; c_read = 1'b0;
        chk("t3_c_resp", c_resp, 1);
        chk("t3_c_rdata", c_rdata, D1);
        tick(); tick();
        chk("t3_empty_nowr", pmem_write, 0);
`endif

        // Coalescing write to the same line: one drain carrying the newer data.
        write_ack("t4_ack1", 16'h1230, D1);
        c_write = 1'b1; c_address = 16'h1230; c_wdata = D2;
        tick();
        tick();
        chk("t4_ack2", c_resp, 1);
        chk("t4_ack2_nowr", pmem_write, 0);
        c_write = 1'b0;
        tick();
        tick();
        chk("t4_drain_wr", pmem_write, 1);
        chk("t4_drain_data", pmem_wdata, D2);
        chk("t4_drain_addr", pmem_address, 16'h1230);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        tick();
        chk("t4_single_wr", pmem_write, 0);

        // Conflicting write: evict 0x1230 first, then accept 0x7770.
        write_ack("t5_ack1", 16'h1230, D1);
        c_write = 1'b1; c_address = 16'h7770; c_wdata = D3;
        tick();
        tick();
        chk("t5_evict_wr", pmem_write, 1);
        chk("t5_evict_addr", pmem_address, 16'h1230);
        chk("t5_evict_data", pmem_wdata, D1);
        chk("t5_wait_noresp", c_resp, 0);
        tick();
        chk("t5_evict_hold", pmem_write, 1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t5_evict_done", pmem_write, 0);
        chk("t5_still_noresp", c_resp, 0);
        tick();
        chk("t5_ack2", c_resp, 1);
        c_write = 1'b0;
        tick();
        tick();
        chk("t5_drain2_addr", pmem_address, 16'h7770);
        chk("t5_drain2_data", pmem_wdata, D3);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;

        // Reset in the middle of a stalled drain discards the buffered line.
        write_ack("t6_ack", 16'h1230, D1);
        tick();
        tick();
        chk("t6_drain_wr", pmem_write, 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_wr", pmem_write, 0);
        chk("t6_rst_addr", pmem_address, 0);
        chk("t6_rst_resp", c_resp, 0);
        tick();
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t6_late_resp_ign", c_resp, 0);
        tick();
        chk("t6_buf_empty", pmem_write, 0);
        chk("t6_no_read", pmem_read, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
